// File: rtl/timer_bank.sv
// Bank of NCH down-counting timers loaded/stopped by a strobed command; commands take effect on the sampling edge.
// No backpressure: one command per cs cycle is always accepted; done/rdy are combinational from registered counts.
module timer_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic [3:0]       op,
  input  logic [7:0]       addr,
  input  logic [15:0]      data_in,
  output logic             rdy,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   expired
);

  typedef enum logic [1:0] {
    OP_LOAD_LO = 2'b00,
    OP_LOAD_HI = 2'b01,
    OP_STOP    = 2'b10,
    OP_MODE    = 2'b11
  } opcode_t;

  logic [WIDTH-1:0] count   [NCH];
  logic [WIDTH-1:0] reload  [NCH];
  logic             running [NCH];
  logic             periodic[NCH];
  logic             exp_q   [NCH];

  logic [23:0]      word;
  logic [WIDTH-1:0] lo_val;
  logic [WIDTH-1:0] hi_val;
  opcode_t          opcode;

  assign word   = {addr, data_in};
  assign lo_val = {{(WIDTH-24){1'b0}}, word};
  // Shifting the WIDTH-bit value drops any bits that land at or above WIDTH.
  assign hi_val = lo_val << 24;
  assign opcode = opcode_t'(op[1:0]);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic hit;
    // Channel indices >= NCH never match any generated channel, so they are ignored.
    assign hit = cs && (op[3:2] == 2'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count[i]    <= '0;
        reload[i]   <= '0;
        running[i]  <= 1'b0;
        periodic[i] <= 1'b0;
        exp_q[i]    <= 1'b0;
      end else if (hit) begin
        case (opcode)
          OP_LOAD_LO: begin
            reload[i]  <= lo_val;
            count[i]   <= lo_val;
            running[i] <= 1'b1;
            exp_q[i]   <= 1'b0;
          end
          OP_LOAD_HI: begin
            reload[i]  <= hi_val;
            count[i]   <= hi_val;
            running[i] <= 1'b1;
            exp_q[i]   <= 1'b0;
          end
          OP_STOP: begin
            count[i]   <= '0;
            running[i] <= 1'b0;
            exp_q[i]   <= 1'b0;
          end
          default: periodic[i] <= data_in[0];
        endcase
      end else if (running[i]) begin
        if (count[i] != '0) begin
          count[i] <= count[i] - WIDTH'(1);
        end else if (periodic[i]) begin
          count[i] <= reload[i];
          exp_q[i] <= 1'b1;
        end else begin
          running[i] <= 1'b0;
          exp_q[i]   <= 1'b1;
        end
      end
    end

    assign done[i]    = (count[i] == '0);
    assign expired[i] = exp_q[i];
  end

  assign rdy = &done;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: a default instance plus a NCH=2/WIDTH=30 instance for
// out-of-range channel and high-load truncation behaviour.
module tb_timer_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs  = 1'b0;
  logic        cs2 = 1'b0;
  logic [3:0]  op = '0;
  logic [7:0]  addr = '0;
  logic [15:0] data_in = '0;
  logic        rdy, rdy2;
  logic [3:0]  done, expired;
  logic [1:0]  done2, expired2;

  int checks = 0;
  int failures = 0;

  timer_bank #(.NCH(4), .WIDTH(48)) dut (
    .clk(clk), .rst(rst), .cs(cs), .op(op), .addr(addr), .data_in(data_in),
    .rdy(rdy), .done(done), .expired(expired)
  );

  timer_bank #(.NCH(2), .WIDTH(30)) dut2 (
    .clk(clk), .rst(rst), .cs(cs2), .op(op), .addr(addr), .data_in(data_in),
    .rdy(rdy2), .done(done2), .expired(expired2)
  );

  always #5 clk = ~clk;

  // Drive at the falling edge, return 1ns after the sampling edge.
  task automatic cmd(input bit sel, input logic [3:0] o, input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    op = o; addr = a; data_in = d;
    if (sel) cs2 = 1'b1; else cs = 1'b1;
    @(posedge clk);
    #1;
    cs = 1'b0; cs2 = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (done !== 4'hF) begin failures++; $display("FAIL reset_done got=%h exp=f", done); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
    checks++; if (expired !== 4'h0) begin failures++; $display("FAIL reset_expired got=%h exp=0", expired); end
    checks++; if (done2 !== 2'b11 || rdy2 !== 1'b1) begin failures++; $display("FAIL reset_dut2 done=%b rdy=%b exp=11/1", done2, rdy2); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_oneshot;
    cmd(0, 4'b0000, 8'h00, 16'h0005);
    checks++; if (dut.count[0] !== 48'd5 || rdy !== 1'b0) begin failures++; $display("FAIL oneshot_load count=%0d rdy=%b exp=5/0", dut.count[0], rdy); end
    for (int k = 1; k <= 5; k++) begin
      step(1);
      checks++;
      if (dut.count[0] !== 48'(5 - k) || done[0] !== (k == 5) || expired[0] !== 1'b0) begin
        failures++; $display("FAIL oneshot_count k=%0d count=%0d done=%b exp_flag=%b exp=%0d/%0d/0", k, dut.count[0], done[0], expired[0], 5 - k, k == 5);
      end
    end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL oneshot_rdy got=%b exp=1", rdy); end
    step(1);
    checks++; if (expired[0] !== 1'b1 || dut.count[0] !== 48'd0) begin failures++; $display("FAIL oneshot_expire expired=%b count=%0d exp=1/0", expired[0], dut.count[0]); end
    step(3);
    checks++; if (expired[0] !== 1'b1 || done[0] !== 1'b1) begin failures++; $display("FAIL oneshot_sticky expired=%b done=%b exp=1/1", expired[0], done[0]); end
  endtask

  task automatic test_periodic;
    cmd(0, 4'b0111, 8'h00, 16'h0001);
    cmd(0, 4'b0100, 8'h00, 16'h0003);
    checks++; if (dut.count[1] !== 48'd3 || expired[1] !== 1'b0) begin failures++; $display("FAIL periodic_load count=%0d expired=%b exp=3/0", dut.count[1], expired[1]); end
    for (int k = 1; k <= 12; k++) begin
      step(1);
      checks++;
      if (done[1] !== (k % 4 == 3) || expired[1] !== (k >= 4)) begin
        failures++; $display("FAIL periodic_cycle k=%0d done=%b expired=%b exp=%0d/%0d", k, done[1], expired[1], k % 4 == 3, k >= 4);
      end
    end
    cmd(0, 4'b0110, 8'h00, 16'h0000);
    checks++; if (dut.count[1] !== 48'd0 || expired[1] !== 1'b0) begin failures++; $display("FAIL periodic_stop count=%0d expired=%b exp=0/0", dut.count[1], expired[1]); end
  endtask

  task automatic test_load_hi;
    cmd(0, 4'b1001, 8'h00, 16'h0001);
    checks++; if (dut.count[2] !== 48'h1000000 || rdy !== 1'b0) begin failures++; $display("FAIL loadhi_value count=%h rdy=%b exp=1000000/0", dut.count[2], rdy); end
    step(9);
    checks++; if (dut.count[2] !== 48'h0FFFFF7) begin failures++; $display("FAIL loadhi_count got=%h exp=fffff7", dut.count[2]); end
    cmd(0, 4'b1010, 8'h00, 16'h0000);
    checks++; if (dut.count[2] !== 48'd0 || rdy !== 1'b1 || expired[2] !== 1'b0) begin failures++; $display("FAIL loadhi_stop count=%0d rdy=%b expired=%b exp=0/1/0", dut.count[2], rdy, expired[2]); end
  endtask

  task automatic test_back_to_back;
    cmd(0, 4'b0000, 8'h00, 16'h0002);
    checks++; if (dut.count[0] !== 48'd2 || expired[0] !== 1'b0) begin failures++; $display("FAIL b2b_load count=%0d expired=%b exp=2/0", dut.count[0], expired[0]); end
    step(2);
    checks++; if (dut.count[0] !== 48'd0 || done[0] !== 1'b1) begin failures++; $display("FAIL b2b_zero count=%0d done=%b exp=0/1", dut.count[0], done[0]); end
    // Reload lands on the edge that would otherwise flag expiry.
    cmd(0, 4'b0000, 8'h00, 16'h0007);
    checks++; if (dut.count[0] !== 48'd7 || expired[0] !== 1'b0 || done[0] !== 1'b0) begin failures++; $display("FAIL b2b_precedence count=%0d expired=%b exp=7/0", dut.count[0], expired[0]); end
    cmd(0, 4'b0100, 8'h00, 16'h0014);
    checks++; if (dut.count[0] !== 48'd6 || dut.count[1] !== 48'd20) begin failures++; $display("FAIL b2b_other_channel ch0=%0d ch1=%0d exp=6/20", dut.count[0], dut.count[1]); end
  endtask

  task automatic test_zero_load;
    cmd(0, 4'b1100, 8'h00, 16'h0000);
    checks++; if (done[3] !== 1'b1 || expired[3] !== 1'b0) begin failures++; $display("FAIL zero_oneshot_load done=%b expired=%b exp=1/0", done[3], expired[3]); end
    step(1);
    checks++; if (expired[3] !== 1'b1) begin failures++; $display("FAIL zero_oneshot_expire got=%b exp=1", expired[3]); end
    cmd(0, 4'b1111, 8'h00, 16'h0001);
    cmd(0, 4'b1100, 8'h00, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      checks++; if (done[3] !== 1'b1 || expired[3] !== 1'b1) begin failures++; $display("FAIL zero_periodic k=%0d done=%b expired=%b exp=1/1", k, done[3], expired[3]); end
    end
  endtask

  task automatic test_reset_mid;
    cmd(0, 4'b1100, 8'h00, 16'd200);
    step(100);
    checks++; if (dut.count[3] !== 48'd100 || expired[0] !== 1'b1) begin failures++; $display("FAIL midreset_pre count=%0d expired0=%b exp=100/1", dut.count[3], expired[0]); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (dut.count[3] !== 48'd0 || done !== 4'hF || rdy !== 1'b1 || expired !== 4'h0) begin
      failures++; $display("FAIL midreset_async count=%0d done=%h rdy=%b expired=%h exp=0/f/1/0", dut.count[3], done, rdy, expired);
    end
    rst = 1'b0;
    cmd(0, 4'b0100, 8'h00, 16'h0003);
    checks++; if (dut.count[1] !== 48'd3) begin failures++; $display("FAIL midreset_first_cmd got=%0d exp=3", dut.count[1]); end
    step(4);
    checks++; if (expired[1] !== 1'b1) begin failures++; $display("FAIL midreset_oneshot_expire got=%b exp=1", expired[1]); end
    step(1);
    checks++; if (dut.count[1] !== 48'd0) begin failures++; $display("FAIL midreset_mode_cleared count=%0d exp=0", dut.count[1]); end
    step(5);
    checks++; if (expired[3] !== 1'b0 || done[3] !== 1'b1) begin failures++; $display("FAIL midreset_no_expiry expired=%b done=%b exp=0/1", expired[3], done[3]); end
  endtask

  task automatic test_bad_channel;
    cmd(1, 4'b0000, 8'h00, 16'd50);
    checks++; if (dut2.count[0] !== 30'd50) begin failures++; $display("FAIL badch_load got=%0d exp=50", dut2.count[0]); end
    cmd(1, 4'b1100, 8'h00, 16'd9);
    cmd(1, 4'b1000, 8'h00, 16'd9);
    checks++; if (dut2.count[0] !== 30'd48 || dut2.count[1] !== 30'd0 || done2 !== 2'b10 || expired2 !== 2'b00) begin
      failures++; $display("FAIL badch_ignored ch0=%0d ch1=%0d done=%b expired=%b exp=48/0/10/00", dut2.count[0], dut2.count[1], done2, expired2);
    end
    cmd(1, 4'b1110, 8'h00, 16'h0000);
    checks++; if (dut2.count[0] !== 30'd47) begin failures++; $display("FAIL badch_stop_ignored got=%0d exp=47", dut2.count[0]); end
    cmd(1, 4'b0101, 8'hAB, 16'hCDEF);
    checks++; if (dut2.count[1] !== 30'h2F000000 || rdy2 !== 1'b0) begin failures++; $display("FAIL loadhi_truncate got=%h rdy=%b exp=2f000000/0", dut2.count[1], rdy2); end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_periodic;
    test_load_hi;
    test_back_to_back;
    test_zero_load;
    test_reset_mid;
    test_bad_channel;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent timer channels (legal range 1..4).
REQ-002 SHALL have parameter WIDTH, default 48, meaning counter width in bits (legal range 25..48).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port cs  input  1  command strobe, one command per high cycle.
REQ-006 SHALL have port op  input  4  command: op[1:0] opcode, op[3:2] channel index.
REQ-007 SHALL have port addr  input  8  high 8 bits of the 24-bit load word.
REQ-008 SHALL have port data_in  input  16  low 16 bits of the load word, or mode bits.
REQ-009 SHALL have port rdy  output  1  high when every channel count equals 0.
REQ-010 SHALL have port done  output  NCH  per-channel level, high while that channel count equals 0.
REQ-011 SHALL have port expired  output  NCH  per-channel sticky expiry flag.

Function
REQ-012 SHALL decode commands on a clk edge with cs=1; cs=0 edges leave the command state untouched.
REQ-013 SHALL ignore commands whose channel index op[3:2] is >= NCH, with no state change.
REQ-014 SHALL treat opcode 00 (LOAD_LO) as: reload[ch] = {zeros, addr, data_in}; count[ch] = that value; running[ch]=1; expired[ch]=0.
REQ-015 SHALL treat opcode 01 (LOAD_HI) as: reload[ch] = {addr, data_in} << 24, bits at or above WIDTH discarded; count[ch] = that value; running[ch]=1; expired[ch]=0.
REQ-016 SHALL treat opcode 10 (STOP) as: count[ch]=0; running[ch]=0; expired[ch]=0; reload[ch] unchanged.
REQ-017 SHALL treat opcode 11 (MODE) as: periodic[ch]=data_in[0]; count, running, reload and expired unchanged.
REQ-018 SHALL make a load visible on the edge that samples it: count=V after edge E, V-1 after E+1; it reaches 0 after edge E+V.
REQ-019 SHALL decrement count by 1 per edge while running=1 and count>0; it never wraps below 0.
REQ-020 SHALL, in one-shot mode (periodic=0) with running=1 and count=0: clear running, set expired, and hold count at 0.
REQ-021 SHALL, in periodic mode with running=1 and count=0: set expired and reload count from reload[ch] on the next edge. Period is V+1 cycles, with done high for 1 cycle each period.
REQ-022 SHALL, for a load of V=0, give done=1 immediately after the load edge. One-shot: expired=1 one edge later. Periodic: done held high continuously.
REQ-023 SHALL give a command that hits a channel precedence over that channel's own decrement, reload or expiry on the same edge.
REQ-024 SHALL let channels not addressed by the command continue counting unaffected on the same edge.
REQ-025 SHALL drive done[i] = (count[i]==0) combinationally from registered count, and rdy = AND of all done bits.
REQ-026 SHALL keep expired[i] set until a LOAD_LO, LOAD_HI or STOP addressed to channel i, or reset.

Reset
REQ-027 SHALL, while rst=1, clear every count, reload, running, periodic and expired bit immediately, without waiting for clk.
REQ-028 SHALL give outputs after reset of done = all ones, rdy=1 and expired = all zeros.
REQ-029 SHALL, on reset mid-count, abandon the count with no expiry. The first edge after rst falls SHALL accept a command normally.

Verification
REQ-030 SHALL cover: LOAD_LO ch0 with addr=0x00, data_in=0x0005 -> count 5,4,3,2,1,0 on the following edges; done[0]=1 and rdy=1 after edge E+5; expired[0]=1 after edge E+6.
REQ-031 SHALL cover: MODE ch1 with data_in=1, then LOAD_LO value 3 -> done[1] pulses once every 4 cycles; expired[1] set after the first pulse and held.
REQ-032 SHALL cover: LOAD_HI ch2 with addr=0x00, data_in=0x0001 -> count=0x1000000 (2^24) and rdy=0. STOP ch2 issued 10 edges later -> count=0, rdy=1, expired[2]=0.
REQ-033 SHALL cover: ch0 loaded with 2 and a LOAD_LO of 7 to ch0 on the edge where count reaches 0 -> the load wins, count=7, expired[0] stays 0.
REQ-034 SHALL cover: rst pulsed between edges while ch3 is at count 100 -> count 0, done=all ones, expired=0 before the next clk edge.
REQ-035 SHALL cover: NCH=2 with command op[3:2]=3 -> no state change on any channel.
